frame_set_writer: RTL and testbench

- Producer side of the frame-set memory that window_handler reads through address_translator.
- Accepts a header byte plus a byte-wide pixel stream: 256 template bytes, then 6400 image bytes (80x80).
- Packs 4 bytes per 32-bit word and writes one frame set of 1665 words into the shared 21-bit-addressed word memory.
- Word layout written is exactly what the read side consumes: offset 0 header, 1..64 template, 65..1664 image.

---
 rtl/frame_set_writer.sv | 158 +++++++++++++++
 tb/tb_frame_set_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_set_writer.sv
// frame_set_writer
//   Producer side of the shared frame-set word memory. A set is one header
//   word followed by TEMPLATE_WORDS template words and IMAGE_WORDS image
//   words. Pixel bytes are packed big-endian, so the first byte of a word
//   lands in [31:24]. The words are written at set_index*SET_WORDS + offset,
//   where offset 0 is the header, 1..64 the template and 65..1664 the image.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      one-cycle request to write a set (ignored while busy)
//   header     header byte, sampled together with start
//   pix_data   pixel byte
//   pix_valid  pix_data valid
//   pix_ready  byte taken on a cycle with pix_valid & pix_ready
//   wr_en      write request, held with wr_addr/wr_data until wr_ready
//   wr_addr    word address
//   wr_data    word data
//   wr_ready   memory takes the write this cycle
//   busy       a set write is in progress
//   set_done   one-cycle pulse after the last image word is accepted
//   set_index  slot index of the current/next set
module frame_set_writer #(
  parameter int TEMPLATE_WORDS = 64,
  parameter int IMAGE_WORDS    = 1600,
  parameter int SET_WORDS      = 1 + TEMPLATE_WORDS + IMAGE_WORDS,
  parameter int MAX_SETS       = 150,
  parameter int ADDR_W         = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        header,
  input  logic [7:0]        pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              set_done,
  output logic [7:0]        set_index
);

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    TEMPLATE,
    IMAGE,
    DONE
  } state_t;

  localparam logic [10:0]       TPL_LAST = 11'(TEMPLATE_WORDS - 1);
  localparam logic [10:0]       IMG_LAST = 11'(IMAGE_WORDS - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(SET_WORDS);
  localparam logic [7:0]        IDX_LAST = 8'(MAX_SETS - 1);

  state_t      state;
  logic [10:0] word_cnt;  // words written in the current phase
  logic [1:0]  byte_cnt;  // bytes already packed into the pending word
  logic [23:0] pack_q;    // first three bytes of the word, oldest on top

  logic byte_acc;
  logic wr_acc;

  assign byte_acc = pix_valid & pix_ready;
  assign wr_acc   = wr_en & wr_ready;

  function automatic logic [31:0] pack_word(input logic [23:0] upper,
                                            input logic [7:0]  last);
    return {upper, last};
  endfunction

  function automatic logic [7:0] next_index(input logic [7:0] idx);
    return (idx == IDX_LAST) ? 8'd0 : idx + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      pix_ready <= 1'b0;
      busy      <= 1'b0;
      set_done  <= 1'b0;
      set_index <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      pack_q    <= '0;
    end else begin
      set_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // The set base goes straight into wr_addr; later words simply
            // walk forward from it one address per accepted write.
            wr_addr  <= ADDR_W'(set_index) * STRIDE;
            wr_data  <= {24'd0, header};
            wr_en    <= 1'b1;
            busy     <= 1'b1;
            word_cnt <= '0;
            byte_cnt <= '0;
            state    <= HEADER;
          end
        end

        HEADER: begin
          if (wr_ready) begin
            wr_en     <= 1'b0;
            wr_addr   <= wr_addr + 1'b1;
            pix_ready <= 1'b1;
            state     <= TEMPLATE;
          end
        end

        TEMPLATE, IMAGE: begin
          // pix_ready is dropped whenever a word is pending, so a byte and a
          // write handshake never happen on the same edge.
          if (wr_acc) begin
            wr_en   <= 1'b0;
            wr_addr <= wr_addr + 1'b1;
            if (state == TEMPLATE && word_cnt == TPL_LAST) begin
              word_cnt  <= '0;
              pix_ready <= 1'b1;
              state     <= IMAGE;
            end else if (state == IMAGE && word_cnt == IMG_LAST) begin
              set_done <= 1'b1;
              state    <= DONE;
            end else begin
              word_cnt  <= word_cnt + 11'd1;
              pix_ready <= 1'b1;
            end
          end else if (byte_acc) begin
            if (byte_cnt == 2'd3) begin
              wr_data   <= pack_word(pack_q, pix_data);
              wr_en     <= 1'b1;
              pix_ready <= 1'b0;
            end else begin
              pack_q <= {pack_q[15:0], pix_data};
            end
            byte_cnt <= byte_cnt + 2'd1;
          end
        end

        DONE: begin
          busy      <= 1'b0;
          set_index <= next_index(set_index);
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_set_writer.sv
// Testbench for frame_set_writer: full-set writes compared with a word-level
// model of the frame-set layout, spot checks from a table, stall, start
// while busy, reset mid-set and the set_index wrap.
module tb_frame_set_writer;

  localparam int NBYTES = 6656;

  logic        clk = 1'b0;
  logic        rst, start, pix_valid, wr_ready;
  logic [7:0]  header, pix_data;
  logic        pix_ready, wr_en, busy, set_done;
  logic [20:0] wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  set_index;

  frame_set_writer dut (
    .clk(clk), .rst(rst), .start(start), .header(header),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .set_done(set_done), .set_index(set_index)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus state ----------------
  logic [7:0] stream [NBYTES];
  bit         gaps, rnd_rdy, start_fired;
  int         stall_addr, stall_left, start_at;
  logic [7:0] start_hdr;

  // ---------------- monitor ----------------
  int unsigned wq_addr [$];
  logic [31:0] wq_data [$];
  int          wq_t    [$];
  int          done_cnt = 0, hold_err = 0, rdy_err = 0, stall_seen = 0, mcyc = 0;
  logic        p_en = 1'b0, p_rdy = 1'b0, p_rst = 1'b1;
  logic [20:0] p_addr = '0;
  logic [31:0] p_data = '0;

  always @(negedge clk) begin
    #2;
    mcyc++;
    if (!rst && !p_rst && p_en && !p_rdy &&
        (!wr_en || wr_addr !== p_addr || wr_data !== p_data))
      hold_err++;
    if (pix_ready && wr_en) rdy_err++;
    if (wr_en && !wr_ready && wr_addr == stall_addr) stall_seen++;
    if (wr_en && wr_ready && !rst) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_t.push_back(mcyc);
    end
    if (set_done) done_cnt++;
    p_en = wr_en; p_rdy = wr_ready; p_rst = rst; p_addr = wr_addr; p_data = wr_data;
  end

  // ---------------- drivers ----------------
  task automatic drive_ready();
    if (stall_left > 0 && wr_en && wr_addr == stall_addr) begin
      wr_ready = 1'b0;
      stall_left--;
    end else begin
      wr_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic stream_bytes(input int from, input int to, output bit ok);
    int i = from;
    int guard = 0;
    bit acc;
    ok = 1'b1;
    while (i < to) begin
      @(negedge clk);
      pix_data  = stream[i];
      pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_ready();
      if (start_at >= 0 && i >= start_at && !start_fired) begin
        start = 1'b1; header = start_hdr; start_fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      acc = pix_valid && pix_ready;
      @(posedge clk);
      if (acc) i++;
      guard++;
      if (guard > 40000) begin ok = 1'b0; break; end
    end
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int guard = 0;
    while (done_cnt == d0 && guard < 20000) begin
      @(negedge clk);
      pix_valid = 1'b0; start = 1'b0;
      drive_ready();
      @(posedge clk);
      guard++;
    end
    repeat (3) begin
      @(negedge clk); pix_valid = 1'b0; drive_ready();
      @(posedge clk);
    end
    ok = (done_cnt != d0);
  endtask

  function automatic logic [31:0] find_word(input int unsigned a);
    foreach (wq_addr[k]) if (wq_addr[k] == a) return wq_data[k];
    return 32'hDEAD_BEEF;
  endfunction

  // Full set: header, all bytes, then the written words are compared with
  // the layout model (offset 0 header, offset k>0 = bytes 4(k-1)..4(k-1)+3).
  task automatic run_set(input logic [7:0] h, input int exp_base,
                         input string tag, input bit do_release);
    int d0, errs, first_bad, n;
    bit ok;
    logic [31:0] ed;
    wq_addr.delete(); wq_data.delete(); wq_t.delete();
    d0 = done_cnt; start_fired = 1'b0;
    @(negedge clk);
    start = 1'b1; header = h; pix_valid = 1'b0; wr_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (do_release) release dut.set_index;
    chk({tag, "_hdr_wr_en"}, wr_en, 1);
    chk({tag, "_hdr_addr"}, wr_addr, exp_base);
    chk({tag, "_hdr_data"}, wr_data, {24'd0, h});
    chk({tag, "_hdr_busy"}, busy, 1);
    chk({tag, "_hdr_pix_ready"}, pix_ready, 0);
    stream_bytes(0, NBYTES, ok);
    chk({tag, "_stream_in_time"}, ok, 1);
    wait_done(d0, ok);
    chk({tag, "_done_in_time"}, ok, 1);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
    chk({tag, "_write_count"}, wq_addr.size(), 1665);
    errs = 0; first_bad = -1;
    n = (wq_addr.size() < 1665) ? wq_addr.size() : 1665;
    for (int k = 0; k < n; k++) begin
      if (k == 0) ed = {24'd0, h};
      else ed = {stream[4*k-4], stream[4*k-3], stream[4*k-2], stream[4*k-1]};
      if (wq_addr[k] != exp_base + k || wq_data[k] !== ed) begin
        errs++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk({tag, "_model_errors"}, errs, 0);
    if (errs != 0) $display("  first differing word offset %0d", first_bad);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } spot_t;

  spot_t spots [5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int exp_idx;
    int sz;

    spots[0] = '{0,    32'h0000_0042};
    spots[1] = '{1,    32'h4143_4143};
    spots[2] = '{64,   32'h4143_4143};
    spots[3] = '{65,   32'h0001_0203};
    spots[4] = '{1664, 32'hFCFD_FEFF};

    rst = 1'b1; start = 1'b0; header = '0; pix_data = '0; pix_valid = 1'b0;
    wr_ready = 1'b0; gaps = 1'b0; rnd_rdy = 1'b0; stall_left = 0;
    stall_addr = -1; start_at = -1; start_hdr = '0; start_fired = 1'b0;

    for (int i = 0; i < 256; i++) stream[i] = (i % 2 == 0) ? 8'h41 : 8'h43;
    for (int i = 0; i < 6400; i++) stream[256 + i] = 8'(i);

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b1; wr_ready = 1'b1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_set_done", set_done, 0);
    chk("rst_set_index", set_index, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_pix_ready", pix_ready, 0);
    chk("idle_wr_en", wr_en, 0);
    pix_valid = 1'b0;

    // ---- set 0 with a 7-cycle stall on template word 3 ----
    exp_idx = 0; stall_addr = 4; stall_left = 7; stall_seen = 0;
    hold_err = 0; rdy_err = 0;
    run_set(8'h42, 0, "set0", 1'b0);
    for (int s = 0; s < 5; s++)
      chk($sformatf("set0_spot_addr_%0d", spots[s].addr),
          find_word(spots[s].addr), spots[s].data);
    sz = wq_t.size();
    chk("set0_word_period", (sz >= 4) ? wq_t[3] - wq_t[2] : -1, 5);
    chk("set0_stall_cycles", stall_seen, 7);
    chk("set0_hold_errors", hold_err, 0);
    chk("set0_ready_while_pending", rdy_err, 0);
    chk("set0_set_index", set_index, 1);
    exp_idx = 1; stall_addr = -1;

    // ---- set 1: byte gaps, start pulsed during IMAGE ----
    gaps = 1'b1; start_at = 256 + 800; start_hdr = 8'h99;
    run_set(8'h42, exp_idx * 1665, "set1", 1'b0);
    sz = wq_addr.size();
    chk("set1_first_addr", (sz > 0) ? wq_addr[0] : -1, 1665);
    chk("set1_last_addr", (sz > 0) ? wq_addr[sz-1] : -1, 3329);
    chk("set1_set_index", set_index, 2);
    exp_idx = 2; start_at = -1;

    // ---- set 2: random data, gaps and wr_ready ----
    for (int i = 0; i < NBYTES; i++) stream[i] = 8'($urandom);
    rnd_rdy = 1'b1; hold_err = 0; rdy_err = 0;
    run_set(8'($urandom), exp_idx * 1665, "set2", 1'b0);
    chk("set2_hold_errors", hold_err, 0);
    chk("set2_ready_while_pending", rdy_err, 0);
    chk("set2_set_index", set_index, 3);
    rnd_rdy = 1'b0; gaps = 1'b0;

    // ---- reset after 2 bytes of image word 10 ----
    for (int i = 0; i < 256; i++) stream[i] = (i % 2 == 0) ? 8'h41 : 8'h43;
    for (int i = 0; i < 6400; i++) stream[256 + i] = 8'(i);
    wq_addr.delete(); wq_data.delete(); wq_t.delete();
    @(negedge clk);
    start = 1'b1; header = 8'h42; pix_valid = 1'b0; wr_ready = 1'b1;
    @(posedge clk);
    stream_bytes(0, 256 + 42, ok);
    chk("midrst_stream_in_time", ok, 1);
    @(negedge clk);
    pix_valid = 1'b0; rst = 1'b1;
    chk("midrst_writes_before", wq_addr.size(), 75);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_set_index", set_index, 0);
    chk("midrst_pix_ready", pix_ready, 0);
    chk("midrst_wr_addr", wr_addr, 0);
    rst = 1'b0;
    exp_idx = 0;

    // ---- fresh set after reset rewrites from address 0 ----
    run_set(8'h42, 0, "set_after_rst", 1'b0);
    chk("after_rst_word65", find_word(65), 32'h0001_0203);
    chk("after_rst_set_index", set_index, 1);

    // ---- set_index 149 and wrap ----
    @(negedge clk);
    force dut.set_index = 8'd149;
    exp_idx = 149;
    run_set(8'h42, exp_idx * 1665, "set149", 1'b1);
    sz = wq_addr.size();
    chk("set149_first_addr", (sz > 0) ? wq_addr[0] : -1, 248085);
    chk("set149_last_addr", (sz > 0) ? wq_addr[sz-1] : -1, 249749);
    chk("set149_wrap_index", set_index, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
